// File: rtl/mac_dot_sequencer.sv
// Operand sequencer for an external 8x8 signed MAC: buffers (a, b) pairs in a FIFO,
// clears the accumulator per vector, issues one start per pair and returns the dot product.
module mac_dot_sequencer #(
    parameter int VEC_LEN    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        mac_clr,
    output logic        mac_start,
    output logic [7:0]  mac_a,
    output logic [7:0]  mac_b,
    input  logic [15:0] mac_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {CLEAR, FEED, WAIT, OUT} state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  fifo_a [FIFO_DEPTH];
    logic [7:0]  fifo_b [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic [7:0]  elem_cnt;
    logic [7:0]  elem_cnt_next;
    logic [15:0] out_q;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready = rst_n && !full;
    assign push     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr[AW-1:0]] <= in_a;
            fifo_b[wr_ptr[AW-1:0]] <= in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= CLEAR;
            elem_cnt <= '0;
            out_q    <= '0;
        end else begin
            state    <= state_next;
            elem_cnt <= elem_cnt_next;
            if (state == WAIT) begin
                out_q <= mac_result;
            end
        end
    end

    // MAC control decodes from the registered state and FIFO head; all quiet in reset.
    always_comb begin
        state_next    = state;
        elem_cnt_next = elem_cnt;
        pop           = 1'b0;
        mac_clr       = !rst_n;
        mac_start     = 1'b0;
        mac_a         = '0;
        mac_b         = '0;
        case (state)
            CLEAR: begin
                mac_clr       = 1'b1;
                elem_cnt_next = '0;
                state_next    = FEED;
            end
            FEED: begin
                if (!empty && rst_n) begin
                    pop           = 1'b1;
                    mac_start     = 1'b1;
                    mac_a         = fifo_a[rd_ptr[AW-1:0]];
                    mac_b         = fifo_b[rd_ptr[AW-1:0]];
                    elem_cnt_next = elem_cnt + 8'd1;
                    if (elem_cnt == 8'(VEC_LEN - 1)) begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                state_next = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_next = CLEAR;
                end
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    assign out_valid = rst_n && (state == OUT);
    assign out_data  = rst_n ? out_q : '0;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer: behavioural MAC, dot-product reference model fed from
// accepted input pairs, and a monitor that scoreboards every result and MAC operand.
module tb_mac_dot_sequencer;
    localparam int VEC_LEN    = 4;
    localparam int FIFO_DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        mac_clr;
    logic        mac_start;
    logic [7:0]  mac_a;
    logic [7:0]  mac_b;
    logic [15:0] mac_result;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    mac_dot_sequencer #(.VEC_LEN(VEC_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mac_clr(mac_clr), .mac_start(mac_start), .mac_a(mac_a), .mac_b(mac_b),
        .mac_result(mac_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in for the external MAC: synchronous clear, one accumulate per start.
    logic [15:0] acc;
    always @(posedge clk) begin
        if (mac_clr) acc <= '0;
        else if (mac_start) acc <= acc + 16'($signed(mac_a) * $signed(mac_b));
    end
    assign mac_result = acc;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic failNow(input string name);
        n_tests++;
        n_fail++;
        $display("[TB] FAIL %s at %0t", name, $time);
    endtask

    logic [15:0] fifo_q[$];
    logic [15:0] exp_q[$];
    int          hs_cycles[$];
    int          pend_sum = 0;
    int          pend_n = 0;
    int          vec_pops = 0;
    int          clr_since = 0;
    int          start_total = 0;
    int          results_seen = 0;
    int          cycle = 0;
    logic        hold_prev = 1'b0;
    logic [15:0] hold_data = '0;
    logic [15:0] last_result = '0;
    logic        rand_ready = 1'b0;

    // Monitor: samples mid-cycle, so a handshake seen here lands on the next rising edge.
    always @(negedge clk) begin
        cycle++;
        if (!rst_n) begin
            checkOutput("reset_outputs", 32'({mac_clr, out_valid, in_ready, mac_start, out_data}),
                        32'({1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}));
            fifo_q.delete();
            exp_q.delete();
            pend_sum  = 0;
            pend_n    = 0;
            vec_pops  = 0;
            clr_since = 0;
            hold_prev = 1'b0;
        end else begin
            checkOutput("in_ready", 32'(in_ready), 32'(fifo_q.size() < FIFO_DEPTH));
            if (mac_clr) clr_since++;
            if (mac_start) begin
                if (fifo_q.size() == 0) begin
                    failNow("mac_start_with_empty_fifo");
                end else begin
                    if (vec_pops == 0) checkOutput("clr_before_vector", 32'(clr_since), 32'd1);
                    checkOutput("mac_operands", 32'({mac_a, mac_b}), 32'(fifo_q.pop_front()));
                    vec_pops++;
                    if (vec_pops == VEC_LEN) vec_pops = 0;
                    start_total++;
                end
            end
            if (hold_prev) begin
                checkOutput("out_valid_held", 32'(out_valid), 32'd1);
                checkOutput("out_data_held", 32'(out_data), 32'(hold_data));
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    failNow("unexpected_out_valid");
                end else begin
                    checkOutput("dot_result", 32'(out_data), 32'(exp_q[0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        results_seen++;
                        last_result = out_data;
                        hs_cycles.push_back(cycle);
                        clr_since = 0;
                    end
                end
            end
            hold_prev = out_valid && !out_ready;
            hold_data = out_data;
            if (in_valid && in_ready) begin
                fifo_q.push_back({in_a, in_b});
                pend_sum += $signed(in_a) * $signed(in_b);
                pend_n++;
                if (pend_n == VEC_LEN) begin
                    exp_q.push_back(16'(pend_sum));
                    pend_sum = 0;
                    pend_n   = 0;
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input int gap);
        bit done;
        int waited;
        done     = 1'b0;
        waited   = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!done) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            waited++;
            if (!done && waited > 200) begin
                failNow("input_accept_timeout");
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitResults(input int target);
        int t;
        t = 0;
        while (results_seen < target && t < 500) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (results_seen < target) failNow("result_timeout");
    endtask

    task automatic sendBasic(input int gap);
        applyStimulus(8'd1, 8'd2, gap);
        applyStimulus(8'd3, 8'd4, gap);
        applyStimulus(8'd5, 8'd6, gap);
        applyStimulus(8'd7, 8'd8, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int s0;
        int t;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("release_mac_clr", 32'(mac_clr), 32'd1);
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);
        checkOutput("release_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Basic vector
        s0 = start_total;
        sendBasic(0);
        waitResults(1);
        checkOutput("basic_result", 32'(last_result), 32'd100);
        checkOutput("basic_starts", 32'(start_total - s0), 32'd4);

        // Stall with idle gaps, plus last-pair latency
        s0 = start_total;
        applyStimulus(8'd1, 8'd2, 3);
        applyStimulus(8'd3, 8'd4, 3);
        applyStimulus(8'd5, 8'd6, 3);
        applyStimulus(8'd7, 8'd8, 0);
        @(negedge clk);
        checkOutput("latency_start_c1", 32'(mac_start), 32'd1);
        @(negedge clk);
        checkOutput("latency_valid_c2", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("latency_valid_c3", 32'(out_valid), 32'd1);
        waitResults(2);
        checkOutput("stall_result", 32'(last_result), 32'd100);
        checkOutput("stall_starts", 32'(start_total - s0), 32'd4);

        // Wrap, then a vector proving the accumulator was cleared
        repeat (VEC_LEN) applyStimulus(8'h80, 8'h7F, 0);
        waitResults(3);
        checkOutput("wrap_result", 32'(last_result), 32'd512);
        repeat (VEC_LEN) applyStimulus(8'hFF, 8'h01, 0);
        waitResults(4);
        checkOutput("cleared_result", 32'(last_result), 32'(16'hFFFC));

        // Throughput with a continuously valid source
        hs_cycles.delete();
        for (int i = 0; i < 3 * VEC_LEN; i++) applyStimulus(8'(i + 1), 8'(2 * i + 3), 0);
        waitResults(7);
        if (hs_cycles.size() >= 3)
            checkOutput("throughput", 32'(hs_cycles[2] - hs_cycles[1]), 32'(VEC_LEN + 3));
        else
            failNow("throughput_missing_results");

        // Backpressure: hold out_ready low while the FIFO fills
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 3 * VEC_LEN; i++) applyStimulus(8'($urandom), 8'($urandom), 0);
            end
            begin
                t = 0;
                while (!out_valid && t < 200) begin
                    @(posedge clk);
                    t++;
                end
                if (!out_valid) failNow("backpressure_no_valid");
                repeat (10) @(posedge clk);
                @(negedge clk);
                checkOutput("bp_fifo_full_ready", 32'(in_ready), 32'd0);
                checkOutput("bp_valid_held", 32'(out_valid), 32'd1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        waitResults(10);

        // Reset mid-vector after two pops
        applyStimulus(8'd9, 8'd9, 0);
        applyStimulus(8'd9, 8'd9, 0);
        applyStimulus(8'd9, 8'd9, 0);
        t = 0;
        while (vec_pops < 2 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midreset_mac_clr", 32'(mac_clr), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midreset_release_clr", 32'(mac_clr), 32'd1);
        checkOutput("midreset_release_ready", 32'(in_ready), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("midreset_no_result", 32'(results_seen), 32'd10);
        sendBasic(0);
        waitResults(11);
        checkOutput("post_reset_result", 32'(last_result), 32'd100);

        // Randomized vectors with random gaps and random out_ready
        rand_ready = 1'b1;
        for (int v = 0; v < 6; v++)
            for (int i = 0; i < VEC_LEN; i++)
                applyStimulus(8'($urandom), 8'($urandom), $urandom_range(0, 2));
        waitResults(17);
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mac_dot_sequencer.md
# mac_dot_sequencer

Operand sequencer that sits directly upstream of the 8x8 signed Booth/Kogge-Stone MAC unit and turns a stream of operand pairs into fixed-length dot products. It buffers incoming (a, b) pairs in a small FIFO and clears the MAC accumulator at the start of each vector. It then issues one MAC `start` per pair, captures the 16-bit accumulator once the last product has landed, and presents it on a valid/ready result port. The MAC itself is external; this block only drives its control and operand inputs and reads its `result`.

## Interface
- `VEC_LEN`, default 4: pairs per dot product. Range 1..255.
- `FIFO_DEPTH`, default 4: operand FIFO entries. Must be a power of 2 and at least 2.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  FIFO can accept; `= !full`.
- `in_a`  in  8  signed multiplicand.
- `in_b`  in  8  signed multiplier.
- `mac_clr`  out  1  accumulator clear, active-high; wired to MAC `rst`.
- `mac_start`  out  1  one accumulate per cycle high; wired to MAC `start`.
- `mac_a`  out  8  operand to MAC `A`.
- `mac_b`  out  8  operand to MAC `B`.
- `mac_result`  in  16  MAC accumulator output.
- `out_valid`  out  1  dot product available.
- `out_ready`  in  1  consumer accepts.
- `out_data`  out  16  signed dot product, two's-complement wrap to 16 bits.

## Operation
- An input transfer occurs when `in_valid && in_ready`. The pair is written at the FIFO tail.
- FIFO rules:
  - No bypass. Data pushed in cycle c is first visible at the head in cycle c+1.
  - Push and pop in the same cycle are both honoured.
  - When full, `in_ready` is 0 even if a pop happens that cycle.
- FSM states are CLEAR, FEED, WAIT and OUT. The reset state is CLEAR.
- CLEAR:
  - `mac_clr=1` for exactly one cycle.
  - Element counter is set to 0.
  - Next state is FEED.
- FEED:
  - Each cycle the FIFO is non-empty: pop the head, drive `mac_start=1`, and set `mac_a/mac_b` to the head pair. Then increment the counter.
  - Each cycle the FIFO is empty: `mac_start=0` and the state holds. Input gaps stall without error.
  - On the pop where counter reaches `VEC_LEN`, the next state is WAIT.
- WAIT (one cycle): the MAC accumulator now holds the final sum. Register `mac_result` into `out_data`. Next state is OUT.
- OUT:
  - `out_valid=1` and `out_data` is held stable.
  - On `out_ready=1`, the next state is CLEAR.
  - The FIFO keeps accepting input throughout WAIT and OUT.
- Outside FEED: `mac_start=0`, and `mac_a`/`mac_b` are driven to 0.
- Arithmetic is done entirely in the MAC. The result wraps modulo 2^16 with no saturation.

## Timing
- All outputs are 0 while `rst_n=0`, except `mac_clr`, which is 1 (state is CLEAR).
- The first cycle after reset release is CLEAR, so `mac_clr=1` for that cycle as well. `in_ready=1` from the first cycle after release.
- Reset mid-operation:
  - FIFO is emptied, counter zeroed, state returns to CLEAR.
  - A partial vector is discarded and no `out_valid` is produced for it.
  - `out_data` resets to 0.
- Back-to-back throughput, FIFO pre-filled: CLEAR(1) + FEED(`VEC_LEN`) + WAIT(1) + OUT(≥1).
  - This is `VEC_LEN`+3 cycles per result when `out_ready` is held high.
- Latency from the last pair's input transfer in cycle c, when the FIFO was otherwise empty and the FSM is in FEED:
  - `mac_start` for that pair in c+1.
  - WAIT in c+2.
  - `out_valid` in c+3.
- `out_valid` and `out_data` are registered. `in_ready`, `mac_start`, `mac_a`, `mac_b` and `mac_clr` decode from registered state and the FIFO head.

## Test plan
- **Basic vector** (`VEC_LEN=4`):
  - Stimulus: pairs (1,2), (3,4), (5,6), (7,8), `out_ready=1`.
  - Required: exactly 4 `mac_start` pulses, then `out_data=100` with `out_valid` for 1 cycle.
  - Required: exactly one `mac_clr` pulse before the first start.
- **Wrap**:
  - Stimulus: four pairs of (-128,127). The true sum is -65024.
  - Required: `out_data=16'd512`.
  - Stimulus: next vector of four (-1,1).
  - Required: `out_data=-4`, proving the accumulator was cleared between vectors.
- **Stall**:
  - Stimulus: pairs with 3 idle cycles between each.
  - Required: `mac_start` is high only on the 4 pop cycles and the result is unchanged (100).
- **Backpressure**:
  - Stimulus: hold `out_ready=0` for 10 cycles while streaming a second vector.
  - Required: `out_data` is stable and `out_valid=1` throughout.
  - Required: the FIFO fills and `in_ready` drops after `FIFO_DEPTH` accepted pairs.
  - Required: after `out_ready` rises, the second result is correct and no pair is lost or duplicated.
- **Reset mid-vector**:
  - Stimulus: assert `rst_n=0` for 1 cycle after 2 of 4 pops.
  - Required: `mac_clr=1`, FIFO empty, and no `out_valid` for the partial vector.
  - Required: the next full vector (1,2)…(7,8) yields 100.
- **Full/simultaneous**:
  - Stimulus: with the FIFO full, present `in_valid=1` in a cycle where FEED pops.
  - Required: `in_ready=0`, so no push that cycle.
  - Required: `in_ready=1` in the following cycle.
